// File: rtl/counter_seq_ctrl.sv
// ----------------------------------------------------------------------------
// counter_seq_ctrl
//   Command-driven up/down counter with a prescaler. Commands arrive over a
//   valid/ready handshake and walk the controller through IDLE, LOAD, RUN
//   and PAUSE. When the count reaches its terminal value it either reloads
//   (periodic mode) or stops and returns to IDLE (one-shot mode). Each
//   terminal event produces a one-cycle tick_done pulse and sets a sticky irq.
//
// Parameters
//   N : counter width in bits
//   P : prescaler width in bits
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cmd_valid    in   command request
//   cmd_ready    out  command accept (low only in LOAD)
//   cmd_op       in   00 START, 01 STOP, 10 RESUME, 11 ABORT
//   cfg_load     in   start/reload value, captured on START
//   cfg_up       in   1 count up, 0 count down, captured on START
//   cfg_periodic in   1 periodic, 0 one-shot, captured on START
//   cfg_presc    in   prescale value, captured on START
//   irq_clr      in   clears irq
//   q            out  current count
//   busy         out  high whenever the controller is not IDLE
//   tick_done    out  one-cycle terminal-count pulse
//   irq          out  sticky terminal-count flag
// ----------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cfg_load,
  input  logic         cfg_up,
  input  logic         cfg_periodic,
  input  logic [P-1:0] cfg_presc,
  input  logic         irq_clr,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         tick_done,
  output logic         irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] PSC_ONE = {{(P-1){1'b0}}, 1'b1};

  state_t         state_q,   state_d;
  logic [N-1:0]   cnt_q,     cnt_d;
  logic [P-1:0]   pcnt_q,    pcnt_d;
  logic [N-1:0]   ld_q,      ld_d;
  logic           up_q,      up_d;
  logic           per_q,     per_d;
  logic [P-1:0]   presc_q,   presc_d;
  logic           tick_q,    tick_d;
  logic           irq_q,     irq_d;

  logic           xfer;
  logic           irq_set;
  logic [N-1:0]   term_val;

  // Terminal value depends on the latched direction.
  function automatic logic [N-1:0] terminal_of(input logic up);
    return up ? {N{1'b1}} : {N{1'b0}};
  endfunction

  // Non-terminal step: modulo-2^N increment or decrement.
  function automatic logic [N-1:0] next_count(input logic [N-1:0] cur,
                                              input logic         up);
    return up ? (cur + CNT_ONE) : (cur - CNT_ONE);
  endfunction

  assign cmd_ready = (state_q != ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign xfer      = cmd_valid && cmd_ready;
  assign term_val  = terminal_of(up_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    ld_d    = ld_q;
    up_d    = up_q;
    per_d   = per_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    irq_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (cmd_op == OP_START) begin
            ld_d    = cfg_load;
            up_d    = cfg_up;
            per_d   = cfg_periodic;
            presc_d = cfg_presc;
            state_d = ST_LOAD;
          end else if (cmd_op == OP_ABORT) begin
            cnt_d  = '0;
            pcnt_d = '0;
          end
        end
      end

      // Single-cycle load; cmd_ready is low here so no command can arrive.
      ST_LOAD: begin
        cnt_d   = ld_q;
        pcnt_d  = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // Any accepted command owns this edge: counting and prescaling
        // are frozen so STOP preserves the prescaler phase exactly.
        if (xfer) begin
          if (cmd_op == OP_STOP) begin
            state_d = ST_PAUSE;
          end else if (cmd_op == OP_ABORT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
          end
        end else if (pcnt_q == presc_q) begin
          pcnt_d = '0;
          if (cnt_q == term_val) begin
            tick_d  = 1'b1;
            irq_set = 1'b1;
            if (per_q) begin
              cnt_d = ld_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = next_count(cnt_q, up_q);
          end
        end else begin
          pcnt_d = pcnt_q + PSC_ONE;
        end
      end

      ST_PAUSE: begin
        if (xfer) begin
          if (cmd_op == OP_RESUME) begin
            state_d = ST_RUN;
          end else if (cmd_op == OP_ABORT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Set wins over a simultaneous clear.
    irq_d = irq_set | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      ld_q    <= '0;
      up_q    <= 1'b0;
      per_q   <= 1'b0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      ld_q    <= ld_d;
      up_q    <= up_d;
      per_q   <= per_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      irq_q   <= irq_d;
    end
  end

  assign q         = cnt_q;
  assign tick_done = tick_q;
  assign irq       = irq_q;

endmodule
